// File: rtl/sync_serial_rx.sv
// Serial frame receiver: start-bit hunt, mid-bit sampling, stop-bit check.
// Optional RX_GLITCH_FILTER_EN: majority-of-3 filter on each sample point.
module sync_serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_sync,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  busy_q, busy_d;
    logic                  prev_q;
    logic                  sample;
    logic                  fall;
    logic                  tick;

    // Counter counts down to zero, so the sample point lands on the reload value + 1 cycles.
    assign tick = (cnt_q == '0);
    assign fall = prev_q & ~rx_sync;

`ifdef RX_GLITCH_FILTER_EN
    // Two stored taps plus the live input form the 3-cycle majority window.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (reset) hist_q <= '1;
        else       hist_q <= {hist_q[0], rx_sync};
    end

    assign sample = (rx_sync & hist_q[0]) | (rx_sync & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample = rx_sync;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
            prev_q  <= rx_sync;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (fall) state_d = START;
            START:     if (tick) state_d = sample ? IDLE : DATA;
            DATA:      if (tick && (idx_q == LAST_IDX)) state_d = STOP;
            STOP:      if (tick) state_d = sample ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_sync) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d  = HALF_LOAD;
                    busy_d = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    cnt_d = FULL_LOAD;
                    idx_d = '0;
                    if (sample) busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = FULL_LOAD;
                    idx_d   = idx_q + 1'b1;
                    shift_d = (shift_q >> 1) | (DATA_BITS'(sample) << (DATA_BITS - 1));
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (sample) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_sync) busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sync_serial_rx.sv
// Self-checking bench for sync_serial_rx (CLKS_PER_BIT=16, DATA_BITS=8).
// Strobe expectations (kind, word, cycle) are queued as frames are driven.
module tb_sync_serial_rx;
    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic [DB-1:0] data;
    logic          data_valid;
    logic          frame_err;
    logic          busy;

    typedef struct {
        logic          good;
        logic [DB-1:0] data;
        int unsigned   cyc;
    } exp_t;

    exp_t          sb[$];
    int unsigned   cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [DB-1:0] last_good = '0;

    sync_serial_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_sync   (rx),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one line cycle, then inspect the outputs of the edge just taken.
    task automatic step(input logic v);
        exp_t e;
        rx = v;
        @(negedge clk);
        if (data_valid === 1'b1 || frame_err === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: valid=%b ferr=%b data=%h cyc=%0d, no strobe expected",
                         data_valid, frame_err, data, cyc);
            end else begin
                e = sb.pop_front();
                if (data_valid !== e.good || frame_err !== !e.good || data !== e.data || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL strobe: got valid=%b ferr=%b data=%h cyc=%0d, expected valid=%b ferr=%b data=%h cyc=%0d",
                             data_valid, frame_err, data, cyc, e.good, !e.good, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    // Full frame; glitch >= 0 inverts the line for one cycle at that data bit's sample point.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int glitch,
                              input logic [DB-1:0] exp);
        exp_t        e;
        logic [DB+1:0] bits;
        logic        v;
        int unsigned t0;
        bits   = {stop, d, 1'b0};
        t0     = cyc + 1;
        e.good = stop;
        e.data = stop ? exp : last_good;
        e.cyc  = t0 + CPB / 2 + (DB + 1) * CPB;
        sb.push_back(e);
        if (stop) last_good = exp;
        for (int b = 0; b < DB + 2; b++) begin
            for (int j = 0; j < CPB; j++) begin
                v = bits[b];
                if (glitch >= 0 && b == glitch + 1 && j == CPB / 2) v = ~v;
                step(v);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(1'b1);
        step(1'b1);
        checks++;
        if (data !== '0 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got data=%h valid=%b ferr=%b busy=%b, expected 00 0 0 0",
                     data, data_valid, frame_err, busy);
        end
        reset = 1'b0;
        last_good = '0;
        idle(4);
    endtask

    task automatic test_single;
        send_frame(8'hA5, 1'b1, -1, 8'hA5);
        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_pending: got %0d outstanding strobes, expected 0", sb.size());
        end
        checks++;
        if (data !== 8'hA5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: got data=%h busy=%b, expected a5 0", data, busy);
        end
    endtask

    task automatic test_back_to_back;
        send_frame(8'h00, 1'b1, -1, 8'h00);
        send_frame(8'hFF, 1'b1, -1, 8'hFF);
        idle(4);
        checks++;
        if (sb.size() != 0 || data !== 8'hFF) begin
            errors++;
            $display("FAIL back_to_back: got pending=%0d data=%h, expected 0 ff", sb.size(), data);
        end
    endtask

    task automatic test_false_start;
        logic exp_busy;
        for (int i = 0; i < 12; i++) begin
            step((i < 3) ? 1'b0 : 1'b1);
            exp_busy = (i < CPB / 2);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL false_start_busy[%0d]: got %b expected %b", i, busy, exp_busy);
            end
        end
        idle(4);
        send_frame(8'h3C, 1'b1, -1, 8'h3C);
        idle(4);
        checks++;
        if (data !== 8'h3C) begin
            errors++;
            $display("FAIL after_false_start: got data=%h expected 3c", data);
        end
    endtask

    task automatic test_frame_err;
        logic bad;
        send_frame(8'h55, 1'b0, -1, 8'h55);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0);
            if (busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL wait_idle_busy: got busy=0 while line low, expected 1");
        end
        checks++;
        if (data !== 8'h3C) begin
            errors++;
            $display("FAIL frame_err_data: got data=%h expected 3c", data);
        end
        step(1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_release: got busy=%b expected 0", busy);
        end
        idle(4);
    endtask

    task automatic test_reset_mid;
        logic [DB-1:0] d;
        d = 8'h81;
        step(1'b0);
        for (int i = 1; i < CPB; i++) step(1'b0);
        for (int b = 0; b < 4; b++)
            for (int j = 0; j < CPB; j++) step(d[b]);
        for (int j = 0; j < 5; j++) step(d[4]);
        reset = 1'b1;
        step(1'b1);
        checks++;
        if (data !== '0 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got data=%h valid=%b ferr=%b busy=%b, expected 00 0 0 0",
                     data, data_valid, frame_err, busy);
        end
        reset = 1'b0;
        last_good = '0;
        idle(CPB * 12);
        send_frame(8'h81, 1'b1, -1, 8'h81);
        idle(4);
        checks++;
        if (data !== 8'h81 || sb.size() != 0) begin
            errors++;
            $display("FAIL after_reset_mid: got data=%h pending=%0d, expected 81 0", data, sb.size());
        end
    endtask

    task automatic test_glitch;
        logic [DB-1:0] exp;
`ifdef RX_GLITCH_FILTER_EN
        exp = 8'h00;
`else
        exp = 8'h04;
`endif
        send_frame(8'h00, 1'b1, 2, exp);
        idle(4);
        checks++;
        if (data !== exp) begin
            errors++;
            $display("FAIL glitch: got data=%h expected %h", data, exp);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_reset_mid();
        test_glitch();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: got %0d outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
